// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver FSM states and parity-type constants with a parameter-string decoder
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  function automatic logic [1:0] par_code(input logic [31:0] s);
    return s == "EVEN" ? PAR_EVEN : s == 32'("ODD") ? PAR_ODD : PAR_NONE;
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchronizer for asynchronous inputs (clk, rst, d -> q), flops reset to all ones
module uart_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s;
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '1;
      q <= '1;
    end else begin
      s <= d;
      q <= s;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver (clk, rst, uart_rxd in; rx_data/rx_valid/rx_ready handshake, rx_perr, rx_ferr, status_irq, status_err out); define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_rx #(
  parameter int BYTESIZE = 8,
  parameter     PARITY   = "NONE",
  parameter int STOPSIZE = 1,
  parameter int N_BIT    = 16,
  parameter int N_LOG    = $clog2(N_BIT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rxd,
  output logic [BYTESIZE-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_perr,
  output logic                rx_ferr,
  output logic                status_irq,
  output logic                status_err
);
  import uart_pkg::*;
  localparam logic [1:0] PT = par_code(PARITY);
  state_t              state;
  logic                line;
  logic [N_LOG-1:0]    cnt;
  logic [3:0]          idx;
  logic [1:0]          vld;
  logic                armed;
  logic [BYTESIZE-1:0] shreg;
  logic                perr;
  logic                ferr;
  logic                tick;
  logic                bit_v;
  uart_sync #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rxd),
    .q   (line)
  );
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (rst) hist <= '1;
    else     hist <= {hist[0], line};
  end
  always_comb begin
    tick  = cnt == N_LOG'(N_BIT / 2 + 1);
    bit_v = (hist[1] & hist[0]) | (hist[1] & line) | (hist[0] & line);
  end
`else
  always_comb begin
    tick  = cnt == N_LOG'(N_BIT / 2);
    bit_v = line;
  end
`endif
  assign status_irq = rx_valid;
  // armed records a genuine high line in IDLE; vld masks the synchronizer's reset value
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      vld        <= '0;
      armed      <= 1'b0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      status_err <= 1'b0;
    end else begin
      vld        <= {vld[0], 1'b1};
      status_err <= 1'b0;
      if (state != IDLE) cnt <= (cnt == N_LOG'(N_BIT - 1)) ? '0 : cnt + 1'b1;
      if (rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          armed <= armed | (line & vld[1]);
          if (armed & ~line) begin
            state <= START;
            cnt   <= '0;
            armed <= 1'b0;
          end
        end
        START: if (tick) begin
          state <= bit_v ? IDLE : DATA;
          idx   <= '0;
          perr  <= 1'b0;
          ferr  <= 1'b0;
        end
        DATA: if (tick) begin
          shreg <= {bit_v, shreg[BYTESIZE-1:1]};
          idx   <= idx + 1'b1;
          if (idx == 4'(BYTESIZE - 1)) begin
            state <= (PT == PAR_NONE) ? STOP : uart_pkg::PARITY;
            idx   <= '0;
          end
        end
        uart_pkg::PARITY: if (tick) begin
          perr  <= ^shreg ^ bit_v ^ (PT == PAR_ODD);
          state <= STOP;
        end
        STOP: if (tick) begin
          ferr <= ferr | ~bit_v;
          idx  <= idx + 1'b1;
          if (idx == 4'(STOPSIZE - 1)) begin
            state <= IDLE;
            if (rx_valid & ~rx_ready) status_err <= 1'b1;
            else begin
              rx_valid <= 1'b1;
              rx_data  <= shreg;
              rx_perr  <= perr;
              rx_ferr  <= ferr | ~bit_v;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BYTESIZE, default 8, data bits per character (5..9).
REQ-002 SHALL have parameter PARITY, default "NONE", parity type "EVEN", "ODD" or "NONE".
REQ-003 SHALL have parameter STOPSIZE, default 1, stop bits checked (1 or 2).
REQ-004 SHALL have parameter N_BIT, default 16, clock cycles per bit (>=4).
REQ-005 SHALL have parameter N_LOG, default $clog2(N_BIT), bit-timing counter width.
REQ-006 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data  output  BYTESIZE  received character, LSB first on line.
REQ-010 SHALL have port rx_valid  output  1  rx_data holds an unconsumed character.
REQ-011 SHALL have port rx_ready  input  1  consumer accepts; transfer when rx_valid & rx_ready.
REQ-012 SHALL have port rx_perr  output  1  parity error flag qualified by rx_valid.
REQ-013 SHALL have port rx_ferr  output  1  framing (stop bit) error flag qualified by rx_valid.
REQ-014 SHALL have port status_irq  output  1  equals rx_valid.
REQ-015 SHALL have port status_err  output  1  one-cycle overrun pulse.

Function
REQ-016 SHALL pass uart_rxd through a 2-flop synchronizer; the "line" below means the synchronizer output.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a line 1->0 edge; the bit counter clears to 0 on that cycle.
REQ-018 SHALL increment the bit counter each cycle outside IDLE, wrap at N_BIT-1, and sample at count N_BIT/2 (integer division).
REQ-019 SHALL, in START, return to IDLE with no flag or output change if the start sample is 1 (false start); otherwise it enters DATA.
REQ-020 SHALL shift BYTESIZE data samples LSB first, then enter PARITY if PARITY!="NONE", else STOP.
REQ-021 SHALL set perr when the received parity bit mismatches (EVEN: XOR of data and parity = 0 expected; ODD: = 1); perr is 0 when PARITY="NONE".
REQ-022 SHALL set ferr if any of the STOPSIZE stop samples is 0.
REQ-023 SHALL enter IDLE on the cycle after the last stop sample, not at the end of the bit.
REQ-024 SHALL, on the cycle after the last stop sample, load rx_data/rx_perr/rx_ferr and set rx_valid, unless rx_valid & ~rx_ready holds.
REQ-025 SHALL, if rx_valid & ~rx_ready at completion, drop the new character, keep the old one, and pulse status_err for one cycle.
REQ-026 SHALL treat completion in the same cycle as an accepted transfer as a load, with rx_valid staying 1 and no overrun.
REQ-027 SHALL clear rx_valid after a transfer when no completion coincides.
REQ-028 SHALL require the line to be seen high in IDLE before a new start is detected, so a held-low break yields a single character with ferr=1.

Reset
REQ-029 SHALL, on rst: state=IDLE, counters=0, synchronizer flops=1, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, status_err=0.
REQ-030 SHALL let rst mid-character abandon the frame without output, and treat a low line after release as no edge until it has been high.

Configuration
REQ-031 SHALL, with UART_RX_MAJORITY_EN defined, take each bit value as the 2-of-3 majority of samples at counts N_BIT/2-1, N_BIT/2 and N_BIT/2+1, with the decision used from count N_BIT/2+1.
REQ-032 SHALL, without UART_RX_MAJORITY_EN, take the single sample at N_BIT/2; timing of all other events is unchanged except as stated in REQ-031.

Structure
REQ-033 SHALL place the FSM state enum and the parity-type constants in shared package uart_pkg.
REQ-034 SHALL implement the 2-flop synchronizer as sub-module uart_sync, which also serves other asynchronous inputs.

Verification (N_BIT=16, BYTESIZE=8, PARITY="NONE", STOPSIZE=1, rx_ready=1 unless stated)
REQ-035 SHALL cover: frame 0xA5 with a valid stop bit -> rx_data=0xA5, rx_perr=0, rx_ferr=0, rx_valid high for one cycle.
REQ-036 SHALL cover: a 5-cycle low glitch on an idle line -> no rx_valid, FSM back in IDLE, a following frame 0x3C received correctly.
REQ-037 SHALL cover: PARITY="EVEN", frame 0x07 with parity bit 0 -> rx_data=0x07, rx_perr=1.
REQ-038 SHALL cover: frame 0x55 with stop bit 0 -> rx_data=0x55, rx_ferr=1; line held low 40 bits -> no further characters until the line goes high.
REQ-039 SHALL cover: rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, status_err pulses once; after rx_ready=1 the next frame 0x33 is delivered.
REQ-040 SHALL cover: rst asserted mid-DATA of frame 0x99 -> outputs at reset values, no character delivered; next frame 0x42 received correctly.
